// File: rtl/instr_pointer.sv
// Instruction-pointer generator feeding the fetch stage.
// Holds the current program address and advances it sequentially, redirects it on
// jump/call/return, or freezes it on stall/halt. A small LIFO of return addresses
// backs call/ret; overflow/underflow are sticky error flags cleared only by reset.
module instr_pointer #(
  parameter int unsigned          WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR  = '0,
  parameter int unsigned          STACK_DEPTH = 8,
  localparam int unsigned         AW          = $clog2(STACK_DEPTH),
  localparam int unsigned         DW          = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] pointer,
  input  logic                 stall,
  input  logic                 jump,
  input  logic                 call,
  input  logic                 ret,
  input  logic [WORD_SIZE-1:0] target,
  input  logic                 halt,
  input  logic                 resume,
  output logic                 running,
  output logic [DW-1:0]        depth,
  output logic                 overflow,
  output logic                 underflow
);

  // The pop index arithmetic relies on the stack size being a power of two.
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("instr_pointer: STACK_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  state_e state_q, state_d;

  logic [WORD_SIZE-1:0] pointer_q, pointer_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [WORD_SIZE-1:0] stack_q [STACK_DEPTH];

  logic [WORD_SIZE-1:0] ptr_inc;
  logic                 stack_empty;
  logic                 stack_full;
  logic [AW-1:0]        push_idx;
  logic [AW-1:0]        top_idx;
  logic                 step_en;
  logic                 push_en;

  // Sequential successor wraps modulo 2^WORD_SIZE; the pushed return address uses it too.
  assign ptr_inc     = pointer_q + WORD_SIZE'(1);
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign push_idx    = depth_q[AW-1:0];
  // Only consulted when the stack is non-empty, so depth-1 never underflows here.
  assign top_idx     = depth_q[AW-1:0] - AW'(1);

  // A RUN step executes only when not stalled and not being halted this edge.
  assign step_en = (state_q == StRun) && !stall && !halt;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: stall freezes both states; halt/resume move between them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (!stall && halt) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!stall && resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running = (state_q == StRun);
  end

  // Datapath next-state: ret > call > jump > sequential, gated by step_en.
  always_comb begin
    pointer_d   = pointer_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
    if (step_en) begin
      if (ret) begin
        // A simultaneous call is dropped.
        if (!stack_empty) begin
          pointer_d = stack_q[top_idx];
          depth_d   = depth_q - DW'(1);
        end else begin
          pointer_d   = ptr_inc;
          underflow_d = 1'b1;
        end
      end else if (call) begin
        // The branch is taken even when the return address cannot be saved.
        pointer_d = target;
        if (!stack_full) begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (jump) begin
        pointer_d = target;
      end else begin
        pointer_d = ptr_inc;
      end
    end
  end

  // Datapath registers: pointer, occupancy and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer_q   <= RESET_ADDR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pointer_q   <= pointer_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage; entries above depth are don't-care but cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else if (push_en) begin
      stack_q[push_idx] <= ptr_inc;
    end
  end

  assign pointer   = pointer_q;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_instr_pointer.sv
// Self-checking bench for instr_pointer: a vector table for the main sequence plus
// hand-written reset and call/ret-overflow sequences, checked through a scoreboard queue.
module tb_instr_pointer;

  localparam int unsigned   WS    = 16;
  localparam logic [WS-1:0] RADDR = 16'h0010;
  localparam int unsigned   SD    = 8;

  // Control bit positions: {stall, halt, ret, call, jump, resume}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b100000;
  localparam logic [5:0] HALT  = 6'b010000;
  localparam logic [5:0] RET   = 6'b001000;
  localparam logic [5:0] CALL  = 6'b000100;
  localparam logic [5:0] JUMP  = 6'b000010;
  localparam logic [5:0] RES   = 6'b000001;

  typedef struct packed {
    logic [WS-1:0] ptr;
    logic          run;
    logic [3:0]    dep;
    logic          ovf;
    logic          udf;
  } obs_t;

  typedef struct {
    logic [5:0]    ctl;
    logic [WS-1:0] tgt;
    obs_t          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WS-1:0] pointer;
  logic          stall, jump, call, ret, halt, resume;
  logic [WS-1:0] target;
  logic          running;
  logic [3:0]    depth;
  logic          overflow, underflow;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  instr_pointer #(
    .WORD_SIZE  (WS),
    .RESET_ADDR (RADDR),
    .STACK_DEPTH(SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pointer  (pointer),
    .stall    (stall),
    .jump     (jump),
    .call     (call),
    .ret      (ret),
    .target   (target),
    .halt     (halt),
    .resume   (resume),
    .running  (running),
    .depth    (depth),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] c, input logic [WS-1:0] t,
                              input logic [WS-1:0] p, input logic r, input int d,
                              input logic o, input logic u);
    vec_t v;
    v.ctl = c;
    v.tgt = t;
    v.exp = '{ptr: p, run: r, dep: 4'(d), ovf: o, udf: u};
    return v;
  endfunction

  task automatic drive(input logic [5:0] c, input logic [WS-1:0] t);
    {stall, halt, ret, call, jump, resume} = c;
    target = t;
  endtask

  // Pops the oldest expectation and compares it with the current DUT outputs.
  task automatic check(input string name);
    obs_t e, a;
    a = '{ptr: pointer, run: running, dep: depth, ovf: overflow, udf: underflow};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got ptr=%h run=%b dep=%0d ovf=%b udf=%b",
               name, a.ptr, a.run, a.dep, a.ovf, a.udf);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got ptr=%h run=%b dep=%0d ovf=%b udf=%b, want ptr=%h run=%b dep=%0d ovf=%b udf=%b",
                 name, a.ptr, a.run, a.dep, a.ovf, a.udf, e.ptr, e.run, e.dep, e.ovf, e.udf);
      end
    end
  endtask

  task automatic step(input vec_t v, input string name);
    drive(v.ctl, v.tgt);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic check_now(input obs_t e, input string name);
    exp_q.push_back(e);
    check(name);
  endtask

  vec_t tbl [29];
  obs_t rst_obs;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WS-1:0] m_ptr;
    logic [WS-1:0] m_stk[$];
    logic          m_ovf;
    logic          m_udf;
    logic [WS-1:0] t;

    //              ctl           tgt       ptr       run dep ovf udf
    tbl[0]  = mk(NONE,            16'h0000, 16'h0011, 1, 0, 0, 0);
    tbl[1]  = mk(NONE,            16'h0000, 16'h0012, 1, 0, 0, 0);
    tbl[2]  = mk(NONE,            16'h0000, 16'h0013, 1, 0, 0, 0);
    tbl[3]  = mk(NONE,            16'h0000, 16'h0014, 1, 0, 0, 0);
    tbl[4]  = mk(JUMP,            16'h0020, 16'h0020, 1, 0, 0, 0);
    tbl[5]  = mk(CALL,            16'h0100, 16'h0100, 1, 1, 0, 0);
    tbl[6]  = mk(NONE,            16'h0000, 16'h0101, 1, 1, 0, 0);
    tbl[7]  = mk(NONE,            16'h0000, 16'h0102, 1, 1, 0, 0);
    tbl[8]  = mk(RET,             16'h0000, 16'h0021, 1, 0, 0, 0);
    tbl[9]  = mk(JUMP,            16'h002F, 16'h002F, 1, 0, 0, 0);
    tbl[10] = mk(NONE,            16'h0000, 16'h0030, 1, 0, 0, 0);
    tbl[11] = mk(HALT | JUMP,     16'h0500, 16'h0030, 0, 0, 0, 0);
    tbl[12] = mk(JUMP,            16'h0500, 16'h0030, 0, 0, 0, 0);
    tbl[13] = mk(CALL,            16'h0600, 16'h0030, 0, 0, 0, 0);
    tbl[14] = mk(RET,             16'h0000, 16'h0030, 0, 0, 0, 0);
    tbl[15] = mk(JUMP | CALL,     16'h0600, 16'h0030, 0, 0, 0, 0);
    tbl[16] = mk(HALT | CALL,     16'h0600, 16'h0030, 0, 0, 0, 0);
    tbl[17] = mk(STALL | RES,     16'h0000, 16'h0030, 0, 0, 0, 0);
    tbl[18] = mk(RES,             16'h0000, 16'h0030, 1, 0, 0, 0);
    tbl[19] = mk(NONE,            16'h0000, 16'h0031, 1, 0, 0, 0);
    tbl[20] = mk(STALL | JUMP,    16'h0700, 16'h0031, 1, 0, 0, 0);
    tbl[21] = mk(STALL | JUMP,    16'h0700, 16'h0031, 1, 0, 0, 0);
    tbl[22] = mk(STALL | JUMP | HALT, 16'h0700, 16'h0031, 1, 0, 0, 0);
    tbl[23] = mk(CALL | RET,      16'h0800, 16'h0032, 1, 0, 0, 1);
    tbl[24] = mk(JUMP,            16'hFFFF, 16'hFFFF, 1, 0, 0, 1);
    tbl[25] = mk(NONE,            16'h0000, 16'h0000, 1, 0, 0, 1);
    tbl[26] = mk(JUMP,            16'hFFFF, 16'hFFFF, 1, 0, 0, 1);
    tbl[27] = mk(CALL,            16'h0200, 16'h0200, 1, 1, 0, 1);
    tbl[28] = mk(RET,             16'h0000, 16'h0000, 1, 0, 0, 1);

    rst_obs = '{ptr: RADDR, run: 1'b1, dep: 4'd0, ovf: 1'b0, udf: 1'b0};

    // Power-on reset
    rst_n = 1'b0;
    drive(NONE, '0);
    #12;
    check_now(rst_obs, "reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Asynchronous reset between edges clears everything immediately
    #2;
    rst_n = 1'b0;
    #1;
    check_now(rst_obs, "async_reset");
    @(posedge clk);
    #1;
    check_now(rst_obs, "reset_held");
    rst_n = 1'b1;
    step(mk(NONE, 16'h0000, 16'h0011, 1, 0, 0, 0), "post_reset_step");
    step(mk(JUMP, 16'h0000, 16'h0000, 1, 0, 0, 0), "jump_zero");

    // Nine nested calls, then nine returns, against a small LIFO model
    m_ptr = 16'h0000;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      t = 16'h1000 + 16'(i * 16);
      if (m_stk.size() < SD) m_stk.push_back(m_ptr + 16'd1);
      else m_ovf = 1'b1;
      m_ptr = t;
      step(mk(CALL, t, m_ptr, 1, m_stk.size(), m_ovf, m_udf), $sformatf("nest_call[%0d]", i));
    end
    for (int i = 0; i < 9; i++) begin
      if (m_stk.size() > 0) begin
        m_ptr = m_stk.pop_back();
      end else begin
        m_ptr = m_ptr + 16'd1;
        m_udf = 1'b1;
      end
      step(mk(RET, 16'h0000, m_ptr, 1, m_stk.size(), m_ovf, m_udf), $sformatf("nest_ret[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_pointer.md
# instr_pointer

Instruction-pointer generator, the stage directly upstream of instruction fetch. It holds the current program address and drives `pointer` into the fetch stage every cycle. Each cycle it advances the address sequentially, redirects it on jump/call/return, or freezes it on stall or halt. A small internal return-address stack supports subroutine call and return.

## Interface
- `WORD_SIZE`, 16: address width in bits.
- `RESET_ADDR`, 0: value loaded into `pointer` on reset.
- `STACK_DEPTH`, 8: return-address stack entries (≥2, power of two).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pointer`  out  WORD_SIZE  current instruction address (registered)
- `stall`  in  1  hold everything this cycle
- `jump`  in  1  load `target` into pointer
- `call`  in  1  push pointer+1, load `target`
- `ret`  in  1  pop stack into pointer
- `target`  in  WORD_SIZE  jump/call destination
- `halt`  in  1  enter HALTED
- `resume`  in  1  leave HALTED
- `running`  out  1  1 in RUN, 0 in HALTED
- `depth`  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- `overflow`  out  1  sticky: call attempted with stack full
- `underflow`  out  1  sticky: ret attempted with stack empty

## Operation
- States: RUN, HALTED. Reset → RUN.
- All commands are sampled at the rising edge of `clk`.
- RUN, per-cycle priority, highest first:
  - `stall`: pointer, stack, state and flags hold; all other inputs are ignored.
  - `halt`: go to HALTED; pointer holds.
  - `ret`:
    - Stack non-empty: pointer ← top of stack; pop.
    - Stack empty: pointer ← pointer+1; `underflow` ← 1.
  - `call`:
    - Stack not full: push pointer+1; pointer ← `target`.
    - Stack full: push is discarded and the stack is unchanged; `overflow` ← 1; pointer ← `target`.
  - `jump`: pointer ← `target`.
  - None of the above: pointer ← pointer+1.
- HALTED:
  - Pointer and stack hold.
  - `resume` (when `stall`=0): go to RUN. The pointer does not advance on the resume edge.
  - `jump`, `call`, `ret` and `halt` are ignored.
- Arithmetic: pointer+1 is computed modulo 2^WORD_SIZE, so 0xFFFF+1 = 0x0000 when WORD_SIZE=16. The pushed value wraps the same way.
- Stack is LIFO with `depth` ranging 0..STACK_DEPTH. Full means `depth`==STACK_DEPTH; empty means `depth`==0.
- `overflow` and `underflow` are sticky until reset.
- Reset asserted mid-operation: all state is lost immediately (asynchronous).

## Timing
- Reset values: `pointer`=RESET_ADDR, `running`=1, `depth`=0, `overflow`=0, `underflow`=0.
- Outputs change only on a rising `clk` edge or on assertion of `rst_n`.
- One-cycle latency: a command sampled at edge n is visible on `pointer` after edge n. The fetch stage registers the instruction one further edge later.
- Releasing `rst_n`: the first edge with `rst_n`=1 performs a normal RUN step. Pointer becomes RESET_ADDR+1 unless a command or stall is present on that edge.
- `running` updates on the same edge as the state transition.
- `stall` and `halt` both high: stall wins and nothing changes that cycle.
- `call` and `ret` both high: `ret` is performed and `call` is dropped.

## Test plan
- Reset then 4 free-running edges (RESET_ADDR=0x0010) → pointer shows 0x0010, 0x0011, 0x0012, 0x0013, 0x0014; `running`=1.
- From pointer 0x0020, `call` with target 0x0100, then 2 free edges, then `ret` → pointer sequence 0x0100, 0x0101, 0x0102, then 0x0021; `depth` goes 1 → 0.
- Nine nested calls with STACK_DEPTH=8 → `overflow`=1 after the 9th, `depth`=8. Then nine rets → 8 correct return addresses, the 9th yields pointer+1 and sets `underflow`=1.
- Pointer at 0xFFFF, free edge → 0x0000. Call at 0xFFFF → pushes 0x0000.
- `halt` at 0x0030 for 5 edges with jump/call toggling, then `resume` → pointer stays 0x0030 through the resume edge, then 0x0031; `running` reads 0 during halt.
- `stall` held 3 edges with `jump`=1 → pointer unchanged. Assert `rst_n`=0 between edges → pointer=RESET_ADDR immediately and flags clear.
